// File: rtl/stall_bubble_controller.sv
// stall_bubble_controller
//   Consumer end of the pipeline stall protocol. Turns the hazard detector's
//   combinational stall request into a PC/IF-ID freeze plus an ID/EX bubble.
//   It owns the IF/ID register, flushes it on a taken branch, and limits how
//   long a stall can last with a sticky watchdog. It also keeps a saturating
//   count of the stall cycles it honoured.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   is_stall      stall request from the hazard detector (same cycle)
//   branch_taken  branch resolved taken this cycle; flush IF/ID
//   if_inst       instruction fetched this cycle
//   if_pc         PC of if_inst
//   pc_write      PC register enable (combinational)
//   ex_bubble     ID/EX loads a NOP with zeroed control this edge (combinational)
//   id_inst       IF/ID instruction (registered)
//   id_pc         IF/ID PC (registered)
//   id_valid      IF/ID holds a real instruction (registered)
//   stall_timeout sticky watchdog flag (registered)
//   stall_total   saturating count of honoured stall cycles (registered)
module stall_bubble_controller #(
    parameter int unsigned PC_WIDTH  = 16,
    parameter logic [18:0] NOP_INST  = 19'b0,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_stall,
    input  logic                branch_taken,
    input  logic [18:0]         if_inst,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                pc_write,
    output logic                ex_bubble,
    output logic [18:0]         id_inst,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic                id_valid,
    output logic                stall_timeout,
    output logic [15:0]         stall_total
);

    localparam logic [7:0] MaxStall = 8'(MAX_STALL);

    typedef enum logic {
        StRun,
        StFlush
    } state_e;

    state_e              state_q, state_d;
    logic [18:0]         id_inst_q, id_inst_d;
    logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
    logic                id_valid_q, id_valid_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         total_q, total_d;
    logic [7:0]          consec_q, consec_d;

    logic stall_req;
    logic stall_eff;
    logic watchdog;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            total_q    <= '0;
            consec_q   <= '0;
        end else begin
            state_q    <= state_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            timeout_q  <= timeout_d;
            total_q    <= total_d;
            consec_q   <= consec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        timeout_d  = timeout_q;
        total_d    = total_q;
        consec_d   = consec_q;

        // A stall only matters when IF/ID holds a real instruction outside FLUSH;
        // a same-cycle branch drops it rather than deferring it.
        stall_req = (state_q == StRun) && is_stall && id_valid_q && !branch_taken;
        stall_eff = stall_req && (consec_q < MaxStall);
        watchdog  = stall_req && (consec_q == MaxStall);

        if (branch_taken) begin
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            consec_d   = '0;
            state_d    = StFlush;
        end else if (stall_eff) begin
            consec_d = consec_q + 8'd1;
            if (total_q != 16'hFFFF) begin
                total_d = total_q + 16'd1;
            end
        end else begin
            id_inst_d  = if_inst;
            id_pc_d    = if_pc;
            id_valid_d = 1'b1;
            consec_d   = '0;
            state_d    = StRun;
            if (watchdog) begin
                timeout_d = 1'b1;
            end
        end

        // id_valid_q is already clear under reset, so only pc_write needs rst.
        pc_write  = !stall_eff && !rst;
        ex_bubble = stall_eff || !id_valid_q || rst;
    end

    assign id_inst       = id_inst_q;
    assign id_pc         = id_pc_q;
    assign id_valid      = id_valid_q;
    assign stall_timeout = timeout_q;
    assign stall_total   = total_q;

endmodule
